pixel_write_queue: RTL
======================

Name: pixel_write_queue

Overview:
- Sits directly downstream of the animated-shape drawing engines and upstream of the VGA adapter write port.
- Accepts the engine's (x, y, colour, plot) pixel stream into a small FIFO.
- Clips off-screen pixels and presents the rest to the adapter with a valid/stall handshake.
- Also provides a full-screen clear sweep so the top level does not need a separate clearing engine.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥ 2.
- ADDR_W, 4, log2(DEPTH).
- SCREEN_W, 160, visible columns; x ≥ SCREEN_W is off-screen.
- SCREEN_H, 120, visible rows; y ≥ SCREEN_H is off-screen.
- CLEAR_COLOUR, 3'b000, colour written during a clear sweep.

Ports:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- in_x, in, 8: pixel x from drawing engine.
- in_y, in, 7: pixel y from drawing engine.
- in_colour, in, 3: pixel colour.
- in_plot, in, 1: pixel request; sampled only when in_ready=1.
- in_ready, out, 1: queue can accept a request this cycle.
- clear_req, in, 1: start a full-screen clear; honoured only in IDLE.
- clear_busy, out, 1: clear is in progress (drain or sweep).
- vga_x, out, 8: pixel x to adapter.
- vga_y, out, 7: pixel y to adapter.
- vga_colour, out, 3: pixel colour to adapter.
- vga_writeEn, out, 1: output pixel valid.
- vga_stall, in, 1: adapter cannot accept this cycle.
- fill_level, out, ADDR_W+1: current FIFO occupancy, 0..DEPTH.
- clip_count, out, 8: off-screen requests discarded; saturates at 255.

Behaviour:
- Reset (synchronous, active-high): FIFO empty, fill_level=0, clip_count=0, vga_writeEn=0, vga_x/y/colour=0, clear_busy=0, state IDLE. Reset overrides every other input, including mid-clear and mid-stall.
- in_ready = (state==IDLE) && (fill_level < DEPTH). It is combinational from registered state.
- Accept: a request is taken on an edge where in_plot=1 and in_ready=1.
  - If in_x < SCREEN_W and in_y < SCREEN_H, the entry is pushed.
  - Otherwise it is not pushed and clip_count increments (saturating at 255).
- Requests with in_ready=0 are ignored and not counted.
- Output stage: a single register holding vga_x/y/colour plus vga_writeEn as its valid bit.
  - A transfer occurs on an edge where vga_writeEn=1 and vga_stall=0.
  - The stage loads when it is empty or transferring this cycle: it pops the FIFO head if fill_level > 0, otherwise vga_writeEn goes to 0.
  - While vga_writeEn=1 and vga_stall=1, all vga_* outputs hold unchanged.
- Latency: with an empty queue and no stall, a pixel accepted at edge N is pushed at N, popped at N+1, and seen with vga_writeEn=1 after edge N+1. That is one cycle of FIFO plus the output register.
- Push and pop on the same edge are permitted when 0 < fill_level < DEPTH; fill_level is then unchanged. Pop requires fill_level > 0 before the edge; there is no bypass from input to output.
- Ordering is strict FIFO. Read and write pointers are ADDR_W bits and wrap modulo DEPTH.
- FSM:
  - IDLE: normal queueing.
    - clear_req=1 → DRAIN, and clear_busy=1 from the next cycle.
    - clear_req while not in IDLE is ignored.
  - DRAIN: in_ready=0 and the FIFO continues to empty.
    - When fill_level==0 and the output stage has no pending pixel (vga_writeEn=0, or transferring this cycle) → SWEEP, with sweep counters cx=0, cy=0.
  - SWEEP: the output stage loads (cx, cy, CLEAR_COLOUR) under the same load rule as the normal output stage. Order is raster, x fastest.
    - After loading cx=SCREEN_W-1, cx wraps to 0 and cy increments.
    - After loading (SCREEN_W-1, SCREEN_H-1) → FINISH.
  - FINISH: wait for the final sweep pixel to transfer, then → IDLE with clear_busy=0 on the following cycle.
- A clear produces exactly SCREEN_W*SCREEN_H transfers (19200 at default), regardless of stalls.
- The sweep counters are 8 bits (cx) and 7 bits (cy).

Test Plan:
- Single pixel, no stall: plot (10,20,3'b101) at cycle 0 → vga_writeEn=1 with (10,20,101) from cycle 2 for exactly 1 cycle; fill_level returns to 0.
- Clipping: plot (160,5), (0,120), (255,127), then (159,119) → clip_count=3; only (159,119) reaches the vga outputs.
- Full / back-pressure: hold vga_stall=1 and push 20 pixels back-to-back → 16 stored in FIFO, in_ready=0 once fill_level=16; the first pixel holds stable on the outputs. Release the stall → exactly 17 transfers in push order (1 output + 16 queued); the 3 requests made while in_ready=0 are lost and not counted.
- Clear: with 3 pixels queued, pulse clear_req → the 3 pixels transfer first, then 19200 transfers from (0,0) to (159,119), all colour 000, in raster order. clear_busy falls after the last transfer; in_ready=0 throughout.
- Stall during sweep: toggle vga_stall randomly during a clear → no pixel is skipped or duplicated; the transfer count is still 19200. A clear_req pulsed mid-sweep has no effect.
- Reset mid-clear: assert reset during SWEEP at (37,12) → next cycle vga_writeEn=0, clear_busy=0, fill_level=0, clip_count=0, in_ready=1.

Source files
------------

// File: rtl/pixel_write_queue.sv
// Pixel FIFO between the shape drawing engines and the VGA adapter write port.
// Clips off-screen requests and can run a full-screen clear sweep.
module pixel_write_queue #(
  parameter int         DEPTH        = 16,
  parameter int         ADDR_W       = 4,
  parameter int         SCREEN_W     = 160,
  parameter int         SCREEN_H     = 120,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_x,
  input  logic [6:0]        in_y,
  input  logic [2:0]        in_colour,
  input  logic              in_plot,
  output logic              in_ready,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic [7:0]        vga_x,
  output logic [6:0]        vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_writeEn,
  input  logic              vga_stall,
  output logic [ADDR_W:0]   fill_level,
  output logic [7:0]        clip_count,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWEEP  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [7:0]      LP_W      = 8'(SCREEN_W);
  localparam logic [6:0]      LP_H      = 7'(SCREEN_H);
  localparam logic [7:0]      LP_X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0]      LP_Y_LAST = 7'(SCREEN_H - 1);
  localparam logic [ADDR_W:0] LP_DEPTH  = (ADDR_W + 1)'(DEPTH);

  state_t              r_state;
  state_t              w_state_next;
  logic [17:0]         r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [7:0]          r_cx;
  logic [6:0]          r_cy;

  logic w_onscreen;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_transfer;
  logic w_load;
  logic w_sweep_last;

  // Handshakes: input side takes a request on an edge with in_plot=1 and
  // in_ready=1; output side transfers on an edge with vga_writeEn=1 and
  // vga_stall=0, and vga_* hold while vga_writeEn=1 and vga_stall=1.
  assign in_ready     = (r_state == ST_IDLE) && (fill_level < LP_DEPTH);
  assign clear_busy   = (r_state != ST_IDLE);
  assign o_dbg_state  = r_state;

  assign w_onscreen   = (in_x < LP_W) && (in_y < LP_H);
  assign w_accept     = in_plot && in_ready;
  assign w_push       = w_accept && w_onscreen;
  assign w_transfer   = vga_writeEn && !vga_stall;
  assign w_load       = !vga_writeEn || w_transfer;
  assign w_pop        = w_load && (fill_level != '0) &&
                        ((r_state == ST_IDLE) || (r_state == ST_DRAIN));
  assign w_sweep_last = (r_cx == LP_X_LAST) && (r_cy == LP_Y_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (clear_req) w_state_next = ST_DRAIN;
      // The output stage must be free too, so queued pixels all leave first.
      ST_DRAIN:  if ((fill_level == '0) && w_load) w_state_next = ST_SWEEP;
      ST_SWEEP:  if (w_load && w_sweep_last) w_state_next = ST_FINISH;
      ST_FINISH: if (w_transfer) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_x, in_y, in_colour};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      fill_level <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clip_count <= '0;
    end else if (w_accept && !w_onscreen && (clip_count != 8'hFF)) begin
      clip_count <= clip_count + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (r_state == ST_DRAIN) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if ((r_state == ST_SWEEP) && w_load) begin
      if (r_cx == LP_X_LAST) begin
        r_cx <= '0;
        r_cy <= r_cy + 7'd1;
      end else begin
        r_cx <= r_cx + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vga_writeEn <= 1'b0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
    end else if (w_load) begin
      if (r_state == ST_SWEEP) begin
        vga_writeEn <= 1'b1;
        vga_x       <= r_cx;
        vga_y       <= r_cy;
        vga_colour  <= CLEAR_COLOUR;
      end else if (w_pop) begin
        vga_writeEn <= 1'b1;
        {vga_x, vga_y, vga_colour} <= r_mem[r_rd_ptr];
      end else begin
        vga_writeEn <= 1'b0;
      end
    end
  end

endmodule
